uart_top: RTL and testbench
===========================

Name: uart_top

Overview:
- Full-duplex UART core with 8N1 framing: 8 data bits, no parity, 1 stop bit, LSB first.
- Contains a programmable baud-tick generator, a 16x-oversampling receiver and a transmitter.
- The bit rate is set at run time through `dvsr`.
- Sits between a parallel byte interface (`din`/`dout` plus single-cycle strobes) and the serial `tx`/`rx` pins.

Parameters:
- DBIT, 8, data bits per frame.
- SB_TICK, 16, oversampling ticks spent in the stop bit (16 = 1 stop bit).
- DVSR_W, 11, width of the baud divisor.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- dvsr  in  11  baud divisor. The sample tick fires every dvsr+1 clocks, so dvsr = f_clk/(16*baud) - 1.
- din  in  8  byte to transmit; sampled on the cycle tx_start is accepted.
- rx  in  1  serial input, idle high.
- tx_start  in  1  one-cycle request to transmit din.
- tx  out  1  serial output, idle high.
- dout  out  8  last received byte.
- rx_done_tick  out  1  one-cycle pulse when dout is updated.
- tx_done_tick  out  1  one-cycle pulse at the end of the transmit stop bit.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - tx=1, dout=0x00, rx_done_tick=0, tx_done_tick=0.
  - Both FSMs go to IDLE; all counters and shift registers clear.
  - Applies mid-frame too: the frame is abandoned, with no done tick.
- Baud generator:
  - 11-bit counter counts 0..dvsr, then wraps to 0.
  - `tick`=1 for the one cycle the counter equals dvsr.
  - dvsr=0 gives a tick every clock.
  - A change to dvsr takes effect on the next wrap. If the counter is already above a newly lowered dvsr, it wraps at 2^11.
  - The generator runs continuously and is shared by rx and tx.
- Receiver FSM (IDLE, START, DATA, STOP), with 4-bit tick counter s, 3-bit bit counter n, and shift register b:
  - IDLE: when rx==0, go to START with s=0.
  - START: count ticks. At s==7 (mid start bit):
    - if rx==0, go to DATA with s=0, n=0;
    - if rx==1, treat it as a glitch and return to IDLE.
  - DATA: at s==15, b <= {rx, b[7:1]} and s=0. If n==DBIT-1, go to STOP; otherwise n++.
  - STOP: at s==SB_TICK-1, dout<=b, rx_done_tick=1 for that cycle, return to IDLE.
  - The stop-bit level is not checked (no framing error output). A line held low therefore yields repeated 0x00 frames.
- Transmitter FSM (IDLE, START, DATA, STOP):
  - IDLE: tx=1. When tx_start=1, latch din into the shift register, set s=0, go to START.
  - tx_start is ignored in every state other than IDLE.
  - START: tx=0 for 16 ticks.
  - DATA: tx=shift[0] for 16 ticks per bit, shifting right; DBIT bits are sent.
  - STOP: tx=1 for SB_TICK ticks. tx_done_tick=1 on the cycle of the final tick; the next state is IDLE.
  - tx_start asserted in that same cycle is ignored; it is accepted from the following cycle.
  - tx is registered (glitch-free).
- Frame timing: one frame lasts 10*16*(dvsr+1) clocks, ± one tick of phase. For dvsr=14 that is 2400 clocks, 240 clocks per bit.
- The receiver and transmitter are fully independent; simultaneous rx and tx frames are supported.

Decomposition:
- Package uart_pkg:
  - state typedef {IDLE, START, DATA, STOP};
  - constants DBIT=8, SB_TICK=16, OVERSAMPLE=16, DVSR_W=11.
- Sub-modules:
  - uart_baud_gen: counter plus tick.
  - uart_rx and uart_tx: one FSM each.
- uart_top only instantiates and wires these.

Test Plan:
- Reset: hold rst=1 for 2 clks with rx=1 -> tx=1, dout=0x00, no done ticks. Then apply dvsr=14 and check tick period = 15 clks.
- TX byte: dvsr=14, din=0x55, one-cycle tx_start -> tx = 0,1,0,1,0,1,0,1,0,1, each level lasting 240±15 clks. tx_done_tick fires once, about 2400 clks after start, then tx stays 1.
- Loopback: tx driven into rx, din=0xA5, tx_start -> rx_done_tick fires once with dout=0xA5. Repeat with 0x00, 0xFF and 0x80.
- Busy / back-to-back: pulse tx_start with din=0x3C mid-frame while 0x55 is sending -> only 0x55 is sent. Pulse tx_start 1 clk after tx_done_tick -> second frame starts immediately.
- Rx held low from reset (dvsr=14) -> rx_done_tick every ~2400 clks with dout=0x00.
- Glitch and reset:
  - a 3-tick low pulse on idle rx -> no rx_done_tick;
  - rst mid-frame (tx or rx) -> tx=1 next clk, no done tick, next frame correct.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types and frame constants.
package uart_pkg;

  localparam int DBIT       = 8;
  localparam int SB_TICK    = 16;
  localparam int OVERSAMPLE = 16;
  localparam int DVSR_W     = 11;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running baud divider producing one 16x-oversampling tick every dvsr+1 clocks.
module uart_baud_gen #(
  parameter int DVSR_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DVSR_W-1:0] dvsr,
  output logic              tick
);

  logic [DVSR_W-1:0] cnt;

  // Count 0..dvsr and wrap; a counter already above a lowered dvsr rolls over at 2^DVSR_W.
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (cnt == dvsr)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == dvsr);

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampling 8N1 receiver; samples each bit at its middle.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx,
  input  logic            tick,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick
);

  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
  localparam logic [3:0]    S_MID  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]    S_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0]    S_STOP = 4'(SB_TICK - 1);

  state_t          state, state_n;
  logic [3:0]      s, s_n;
  logic [NW-1:0]   n, n_n;
  logic [DBIT-1:0] b, b_n;
  logic            done_n;
  logic            rx_m, rx_s;

  // Two-flop synchronizer for the asynchronous serial pin; idles high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // State, counters, shift register and output byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      s            <= '0;
      n            <= '0;
      b            <= '0;
      dout         <= '0;
      rx_done_tick <= 1'b0;
    end else begin
      state        <= state_n;
      s            <= s_n;
      n            <= n_n;
      b            <= b_n;
      rx_done_tick <= done_n;
      if (done_n)
        dout <= b;
    end
  end

  // Next-state logic; a start bit that is high again at its middle is a glitch.
  always_comb begin
    state_n = state;
    s_n     = s;
    n_n     = n;
    b_n     = b;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          s_n     = '0;
        end
      end
      START: begin
        if (tick) begin
          if (s == S_MID) begin
            if (!rx_s) begin
              state_n = DATA;
              s_n     = '0;
              n_n     = '0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s == S_LAST) begin
            s_n = '0;
            b_n = {rx_s, b[DBIT-1:1]};
            if (n == N_LAST)
              state_n = STOP;
            else
              n_n = n + 1'b1;
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (s == S_STOP) begin
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 transmitter; the line is driven from a register so it never glitches.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tx_start,
  input  logic            tick,
  input  logic [DBIT-1:0] din,
  output logic            tx,
  output logic            tx_done_tick
);

  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
  localparam logic [3:0]    S_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0]    S_STOP = 4'(SB_TICK - 1);

  state_t          state, state_n;
  logic [3:0]      s, s_n;
  logic [NW-1:0]   n, n_n;
  logic [DBIT-1:0] b, b_n;
  logic            tx_n;

  // State, counters, shift register and the registered line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      s     <= '0;
      n     <= '0;
      b     <= '0;
      tx    <= 1'b1;
    end else begin
      state <= state_n;
      s     <= s_n;
      n     <= n_n;
      b     <= b_n;
      tx    <= tx_n;
    end
  end

  // Next-state logic; requests are only looked at in IDLE.
  always_comb begin
    state_n      = state;
    s_n          = s;
    n_n          = n;
    b_n          = b;
    tx_n         = 1'b1;
    tx_done_tick = 1'b0;
    case (state)
      IDLE: begin
        if (tx_start) begin
          state_n = START;
          s_n     = '0;
          b_n     = din;
        end
      end
      START: begin
        tx_n = 1'b0;
        if (tick) begin
          if (s == S_LAST) begin
            state_n = DATA;
            s_n     = '0;
            n_n     = '0;
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
      DATA: begin
        tx_n = b[0];
        if (tick) begin
          if (s == S_LAST) begin
            s_n = '0;
            b_n = b >> 1;
            if (n == N_LAST)
              state_n = STOP;
            else
              n_n = n + 1'b1;
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (s == S_STOP) begin
            tx_done_tick = 1'b1;
            state_n      = IDLE;
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: rtl/uart_top.sv
// Full-duplex 8N1 UART: shared baud generator feeding independent rx and tx.
module uart_top
  import uart_pkg::*;
#(
  parameter int DBIT    = uart_pkg::DBIT,
  parameter int SB_TICK = uart_pkg::SB_TICK,
  parameter int DVSR_W  = uart_pkg::DVSR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DVSR_W-1:0] dvsr,
  input  logic [DBIT-1:0]   din,
  input  logic              rx,
  input  logic              tx_start,
  output logic              tx,
  output logic [DBIT-1:0]   dout,
  output logic              rx_done_tick,
  output logic              tx_done_tick
);

  logic tick;

  uart_baud_gen #(.DVSR_W(DVSR_W)) u_baud (
    .clk  (clk),
    .rst  (rst),
    .dvsr (dvsr),
    .tick (tick)
  );

  uart_rx #(.DBIT(DBIT), .SB_TICK(SB_TICK)) u_rx (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .tick         (tick),
    .dout         (dout),
    .rx_done_tick (rx_done_tick)
  );

  uart_tx #(.DBIT(DBIT), .SB_TICK(SB_TICK)) u_tx (
    .clk          (clk),
    .rst          (rst),
    .tx_start     (tx_start),
    .tick         (tick),
    .din          (din),
    .tx           (tx),
    .tx_done_tick (tx_done_tick)
  );

endmodule

// File: tb/tb_uart_top.sv
// Directed bench for uart_top: reset, baud tick, tx waveform, loopback and corner cases.
module tb_uart_top;

  typedef struct {
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] dvsr = 11'd14;
  logic [7:0]  din = 8'h00;
  logic        rx_drv = 1'b1;
  logic        loop_en = 1'b0;
  logic        tx_start = 1'b0;
  logic        rx_w;
  logic        tx;
  logic [7:0]  dout;
  logic        rx_done_tick;
  logic        tx_done_tick;
  logic        tick_mon;

  int cyc = 0;
  int rx_cnt = 0;
  int tx_cnt = 0;
  int n_checks = 0;
  int n_errors = 0;

  assign rx_w     = loop_en ? tx : rx_drv;
  assign tick_mon = dut.tick;

  uart_top dut (
    .clk          (clk),
    .rst          (rst),
    .dvsr         (dvsr),
    .din          (din),
    .rx           (rx_w),
    .tx_start     (tx_start),
    .tx           (tx),
    .dout         (dout),
    .rx_done_tick (rx_done_tick),
    .tx_done_tick (tx_done_tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_done_tick) rx_cnt <= rx_cnt + 1;
    if (tx_done_tick) tx_cnt <= tx_cnt + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // which: 0 rx_done_tick, 1 tx_done_tick, 2 tx low, 3 baud tick
  task automatic wait_for(input int which, input int budget, output int ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((which == 0 && rx_done_tick) || (which == 1 && tx_done_tick) ||
          (which == 2 && !tx) || (which == 3 && tick_mon)) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    din      = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  initial begin
    vec_t vecs[4];
    int   lev[9];
    int   ok, t0, t_start, dur, lows, rx_base, tx_base;

    vecs[0] = '{din: 8'hA5, exp: 8'hA5};
    vecs[1] = '{din: 8'h00, exp: 8'h00};
    vecs[2] = '{din: 8'hFF, exp: 8'hFF};
    vecs[3] = '{din: 8'h80, exp: 8'h80};
    lev     = '{0, 1, 0, 1, 0, 1, 0, 1, 0};

    // reset state
    repeat (2) @(negedge clk);
    check("rst_tx", int'(tx), 1);
    check("rst_dout", int'(dout), 0);
    check("rst_rx_done", int'(rx_done_tick), 0);
    check("rst_tx_done", int'(tx_done_tick), 0);
    rst = 1'b0;

    // baud tick period
    wait_for(3, 50, ok);
    check("tick_seen", ok, 1);
    t0 = cyc;
    wait_for(3, 50, ok);
    check("tick_period", cyc - t0, 15);

    // single 0x55 frame, level by level
    tx_base = tx_cnt;
    t_start = cyc;
    send(8'h55);
    wait_for(2, 20, ok);
    check("tx_start_edge", ok, 1);
    for (int i = 0; i < 9; i++) begin
      check($sformatf("tx_lvl%0d", i), int'(tx), lev[i]);
      t0 = cyc;
      for (int j = 0; j < 400; j++) begin
        @(negedge clk);
        if (int'(tx) != lev[i]) break;
      end
      dur = cyc - t0;
      check_rng($sformatf("tx_len%0d", i), dur, 225, 255);
    end
    check("tx_stop_lvl", int'(tx), 1);
    wait_for(1, 400, ok);
    check("tx_done_seen", ok, 1);
    check_rng("tx_frame_len", cyc - t_start, 2370, 2430);
    lows = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!tx) lows++;
    end
    check("tx_idle_after", lows, 0);
    check("tx_done_count", tx_cnt - tx_base, 1);

    // loopback table
    loop_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      rx_base = rx_cnt;
      send(vecs[k].din);
      wait_for(0, 3000, ok);
      check($sformatf("loop%0d_rx_done", k), ok, 1);
      check($sformatf("loop%0d_dout", k), int'(dout), int'(vecs[k].exp));
      wait_for(1, 3000, ok);
      check($sformatf("loop%0d_tx_done", k), ok, 1);
      repeat (5) @(negedge clk);
      check($sformatf("loop%0d_rx_count", k), rx_cnt - rx_base, 1);
    end

    // request while busy is dropped
    rx_base = rx_cnt;
    tx_base = tx_cnt;
    send(8'h55);
    repeat (1000) @(negedge clk);
    send(8'h3C);
    wait_for(0, 3000, ok);
    check("busy_rx_done", ok, 1);
    check("busy_dout", int'(dout), 8'h55);
    repeat (3000) @(negedge clk);
    check("busy_rx_count", rx_cnt - rx_base, 1);
    check("busy_tx_count", tx_cnt - tx_base, 1);

    // back-to-back frames
    send(8'h12);
    wait_for(0, 3000, ok);
    check("b2b_first_rx", ok, 1);
    check("b2b_first_dout", int'(dout), 8'h12);
    wait_for(1, 3000, ok);
    check("b2b_first_done", ok, 1);
    @(negedge clk);
    din      = 8'h34;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    wait_for(2, 3, ok);
    check("b2b_second_start", ok, 1);
    wait_for(0, 3000, ok);
    check("b2b_second_rx", ok, 1);
    check("b2b_second_dout", int'(dout), 8'h34);
    wait_for(1, 3000, ok);
    check("b2b_second_done", ok, 1);

    // glitch on idle rx
    loop_en = 1'b0;
    rx_drv  = 1'b1;
    repeat (20) @(negedge clk);
    rx_base = rx_cnt;
    rx_drv  = 1'b0;
    repeat (45) @(negedge clk);
    rx_drv  = 1'b1;
    repeat (3000) @(negedge clk);
    check("glitch_no_rx", rx_cnt - rx_base, 0);

    // reset in the middle of a frame (tx and looped-back rx)
    loop_en = 1'b1;
    repeat (5) @(negedge clk);
    send(8'h5A);
    repeat (300) @(negedge clk);
    check("mid_tx_low", int'(tx), 0);
    rx_base = rx_cnt;
    tx_base = tx_cnt;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_tx", int'(tx), 1);
    check("mid_rst_dout", int'(dout), 0);
    rst = 1'b0;
    repeat (3000) @(negedge clk);
    check("mid_rst_no_rx", rx_cnt - rx_base, 0);
    check("mid_rst_no_tx", tx_cnt - tx_base, 0);
    send(8'hC3);
    wait_for(0, 3000, ok);
    check("post_rst_rx", ok, 1);
    check("post_rst_dout", int'(dout), 8'hC3);
    wait_for(1, 3000, ok);
    check("post_rst_tx_done", ok, 1);

    // rx held low from reset: repeated 0x00 frames
    loop_en = 1'b0;
    rx_drv  = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_for(0, 3000, ok);
    check("low_rx_first", ok, 1);
    check("low_dout_first", int'(dout), 0);
    t0 = cyc;
    wait_for(0, 3000, ok);
    check("low_rx_second", ok, 1);
    check("low_dout_second", int'(dout), 0);
    check_rng("low_rx_interval", cyc - t0, 2200, 2500);
    rx_drv = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
